// File: rtl/core_ifetch.sv
// Instruction-fetch stage: owns the fetch PC and issues one read at a time
// over an AXI-lite-style read channel, with flush redirects and sticky faults.
module core_ifetch #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN       = 32'h0000_0013,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PC_WRITE,
  input  logic [31:0] PC_NEXT,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] PC,
  output logic [31:0] INSTRUCTION,
  output logic        IMEM_BUSY,
  output logic        IMEM_DONE,
  output logic        FAULT,
  output logic        M_ARVALID,
  input  logic        M_ARREADY,
  output logic [31:0] M_ARADDR,
  input  logic        M_RVALID,
  output logic        M_RREADY,
  input  logic [31:0] M_RDATA,
  input  logic [1:0]  M_RRESP
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_HOLD,
    S_FAULT
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[7:0];

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] pc, pc_n;
  logic [31:0] insn, insn_n;
  logic [31:0] araddr, araddr_n;
  logic        discard, discard_n;
  logic [7:0]  tcount, tcount_n;

  logic        accept_redirect;
  logic        redirect_bad;
  logic        next_bad;
  logic        timed_out;

  assign accept_redirect = REDIRECT && (state != S_FAULT);
  assign redirect_bad    = REDIRECT_PC[1:0] != 2'b00;
  assign next_bad        = PC_NEXT[1:0] != 2'b00;
  assign timed_out       = (tcount + 8'd1) == TIMEOUT_LIMIT;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_VECTOR;
      pc       <= RESET_VECTOR;
      insn     <= NOP_INSN;
      araddr   <= '0;
      discard  <= 1'b0;
      tcount   <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      pc       <= pc_n;
      insn     <= insn_n;
      araddr   <= araddr_n;
      discard  <= discard_n;
      tcount   <= tcount_n;
    end
  end

  // A redirect while a discard is already pending only retargets fetch_pc;
  // PC/INSTRUCTION already show the flushed NOP from the first redirect.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    pc_n       = pc;
    insn_n     = insn;
    araddr_n   = araddr;
    discard_n  = discard;
    tcount_n   = tcount;

    if (accept_redirect) begin
      fetch_pc_n = REDIRECT_PC;
      if (!discard) begin
        pc_n   = REDIRECT_PC;
        insn_n = NOP_INSN;
      end
    end

    case (state)
      S_IDLE: begin
        state_n  = S_ADDR;
        araddr_n = fetch_pc;
        tcount_n = '0;
        if (accept_redirect) begin
          araddr_n = REDIRECT_PC;
          if (redirect_bad) state_n = S_FAULT;
        end
      end

      S_ADDR: begin
        tcount_n = tcount + 8'd1;
        if (accept_redirect && redirect_bad) begin
          state_n = S_FAULT;
          pc_n    = REDIRECT_PC;
        end else begin
          if (accept_redirect) discard_n = 1'b1;
          if (M_ARREADY) begin
            state_n = S_DATA;
          end else if (timed_out) begin
            state_n = S_FAULT;
            pc_n    = araddr;
          end
        end
      end

      // Bus completion is tested before the timeout so a beat that lands on
      // the last allowed cycle is still accepted.
      S_DATA: begin
        tcount_n = tcount + 8'd1;
        if (accept_redirect && redirect_bad) begin
          state_n = S_FAULT;
          pc_n    = REDIRECT_PC;
        end else if (M_RVALID) begin
          if (accept_redirect) begin
            discard_n = 1'b0;
            state_n   = S_ADDR;
            araddr_n  = REDIRECT_PC;
            tcount_n  = '0;
          end else if (discard) begin
            discard_n = 1'b0;
            state_n   = S_ADDR;
            araddr_n  = fetch_pc;
            tcount_n  = '0;
          end else if (M_RRESP != 2'b00) begin
            state_n = S_FAULT;
            pc_n    = araddr;
          end else begin
            insn_n  = M_RDATA;
            pc_n    = fetch_pc;
            state_n = S_HOLD;
          end
        end else begin
          if (accept_redirect) discard_n = 1'b1;
          if (timed_out) begin
            state_n = S_FAULT;
            pc_n    = araddr;
          end
        end
      end

      S_HOLD: begin
        if (accept_redirect) begin
          if (redirect_bad) begin
            state_n = S_FAULT;
          end else begin
            state_n  = S_ADDR;
            araddr_n = REDIRECT_PC;
            tcount_n = '0;
          end
        end else if (PC_WRITE) begin
          fetch_pc_n = PC_NEXT;
          if (next_bad) begin
            state_n = S_FAULT;
            pc_n    = PC_NEXT;
          end else begin
            state_n  = S_ADDR;
            araddr_n = PC_NEXT;
            tcount_n = '0;
          end
        end
      end

      default: begin
        state_n = S_FAULT;
      end
    endcase
  end

  assign PC          = pc;
  assign INSTRUCTION = insn;
  assign M_ARADDR    = araddr;
  assign M_ARVALID   = state == S_ADDR;
  assign M_RREADY    = state == S_DATA;
  assign IMEM_BUSY   = (state == S_ADDR) || (state == S_DATA);
  assign IMEM_DONE   = state == S_HOLD;
  assign FAULT       = state == S_FAULT;

endmodule

// File: tb/tb_core_ifetch.sv
// Self-checking bench for core_ifetch: directed sequence plus randomized
// fetch/redirect traffic against a transaction-level memory and fetch model.
module tb_core_ifetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PC_WRITE = 1'b0;
  logic [31:0] PC_NEXT = '0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic [31:0] PC, INSTRUCTION, M_ARADDR;
  logic        IMEM_BUSY, IMEM_DONE, FAULT, M_ARVALID, M_RREADY;
  logic        M_ARREADY, M_RVALID;
  logic [31:0] M_RDATA;
  logic [1:0]  M_RRESP;

  int vectors = 0;
  int miscompares = 0;

  int          ar_delay = 0;
  int          r_delay = 0;
  bit          ar_stall = 1'b0;
  logic [1:0]  resp_code = 2'b00;
  logic [31:0] ar_log[$];

  always #5 CLK = ~CLK;

  core_ifetch dut (
    .CLK(CLK), .RST(RST), .PC_WRITE(PC_WRITE), .PC_NEXT(PC_NEXT),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .PC(PC),
    .INSTRUCTION(INSTRUCTION), .IMEM_BUSY(IMEM_BUSY), .IMEM_DONE(IMEM_DONE),
    .FAULT(FAULT), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_ARADDR(M_ARADDR), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0] ^ 16'hC3A5, a[17:2] + 16'h1357};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory slave: acts 2ns after each rising edge, knowing what it drove
  // across that edge and what the DUT presented just before it.
  initial begin : mem_slave
    logic        s_arvalid, s_rready, pend;
    logic [31:0] s_araddr, pend_addr;
    int          ar_seen, r_seen;
    s_arvalid = 1'b0; s_rready = 1'b0; s_araddr = '0;
    pend = 1'b0; pend_addr = '0; ar_seen = 0; r_seen = 0;
    M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = 2'b00;
    forever begin
      @(posedge CLK);
      #2;
      if (RST) begin
        M_ARREADY = 1'b0; M_RVALID = 1'b0; pend = 1'b0; ar_seen = 0; r_seen = 0;
      end else begin
        if (s_arvalid && !M_ARREADY && !FAULT) begin
          check("arvalid_held", {31'b0, M_ARVALID}, 32'd1);
          check("araddr_held", M_ARADDR, s_araddr);
        end
        if (s_rready && M_RVALID) begin
          M_RVALID = 1'b0;
          pend = 1'b0;
        end
        if (s_arvalid && M_ARREADY) begin
          ar_log.push_back(s_araddr);
          pend_addr = s_araddr; pend = 1'b1; r_seen = 0;
          M_ARREADY = 1'b0; ar_seen = 0;
        end
        if (M_ARVALID && !M_ARREADY) begin
          if (!ar_stall && ar_seen >= ar_delay) M_ARREADY = 1'b1;
          else ar_seen++;
        end else if (!M_ARVALID) begin
          M_ARREADY = 1'b0;
        end
        if (pend && !M_RVALID) begin
          if (r_seen >= r_delay) begin
            M_RVALID = 1'b1; M_RDATA = mem_word(pend_addr); M_RRESP = resp_code;
          end else begin
            r_seen++;
          end
        end
      end
      s_arvalid = M_ARVALID; s_araddr = M_ARADDR; s_rready = M_RREADY;
    end
  end

  task automatic reset_dut(input int n);
    RST = 1'b1; PC_WRITE = 1'b0; REDIRECT = 1'b0;
    repeat (n) @(negedge CLK);
    check("rst_fault", {31'b0, FAULT}, 32'd0);
    check("rst_done", {31'b0, IMEM_DONE}, 32'd0);
    check("rst_busy", {31'b0, IMEM_BUSY}, 32'd0);
    check("rst_arvalid", {31'b0, M_ARVALID}, 32'd0);
    check("rst_rready", {31'b0, M_RREADY}, 32'd0);
    check("rst_pc", PC, 32'h0);
    check("rst_insn", INSTRUCTION, NOP);
    RST = 1'b0;
  endtask

  task automatic pulse_pc_write(input logic [31:0] a);
    PC_WRITE = 1'b1; PC_NEXT = a;
    @(negedge CLK);
    PC_WRITE = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [31:0] a);
    REDIRECT = 1'b1; REDIRECT_PC = a;
    @(negedge CLK);
    REDIRECT = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge CLK);
      cycles++;
    end while (!IMEM_DONE && cycles < budget);
    check({tag, "_done"}, {31'b0, IMEM_DONE}, 32'd1);
  endtask

  task automatic wait_fault(input string tag, input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge CLK);
      cycles++;
    end while (!FAULT && cycles < budget);
    check({tag, "_fault"}, {31'b0, FAULT}, 32'd1);
  endtask

  task automatic fetch_check(input string tag, input logic [31:0] a);
    check({tag, "_pc"}, PC, a);
    check({tag, "_insn"}, INSTRUCTION, mem_word(a));
    check({tag, "_lastar"}, (ar_log.size() > 0) ? ar_log[$] : 32'hDEAD_BEEF, a);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int cyc, n0, bad, k, arv;
    logic [31:0] t1, t2;

    // Reset vector and minimum zero-wait latency.
    reset_dut(3);
    @(negedge CLK);
    check("first_arvalid", {31'b0, M_ARVALID}, 32'd1);
    check("first_araddr", M_ARADDR, 32'h0);
    @(negedge CLK);
    check("first_data_notdone", {31'b0, IMEM_DONE}, 32'd0);
    check("first_rready", {31'b0, M_RREADY}, 32'd1);
    @(negedge CLK);
    check("first_done", {31'b0, IMEM_DONE}, 32'd1);
    fetch_check("first", 32'h0);

    // Stall in HOLD, then a sequential fetch with delayed ARREADY.
    bad = 0;
    repeat (5) begin
      @(negedge CLK);
      if (!IMEM_DONE || PC !== 32'h0 || INSTRUCTION !== mem_word(32'h0)) bad++;
    end
    check("hold_stable", 32'(bad), 32'd0);
    ar_delay = 2;
    pulse_pc_write(32'h4);
    wait_done("seq4", 40, cyc);
    check("seq4_latency", 32'(cyc), 32'd4);
    fetch_check("seq4", 32'h4);
    ar_delay = 0;

    // Redirect while waiting for late read data.
    r_delay = 3;
    n0 = ar_log.size();
    pulse_pc_write(32'h8);
    for (int i = 0; i < 10 && !M_RREADY; i++) @(negedge CLK);
    pulse_redirect(32'h100);
    check("rd_data_nop", INSTRUCTION, NOP);
    check("rd_data_pc", PC, 32'h100);
    bad = 0;
    for (int i = 0; i < 40 && !IMEM_DONE; i++) begin
      if (INSTRUCTION !== NOP) bad++;
      @(negedge CLK);
    end
    check("rd_nop_until_done", 32'(bad), 32'd0);
    check("rd_done", {31'b0, IMEM_DONE}, 32'd1);
    fetch_check("rd100", 32'h100);
    check("rd_ar_count", 32'(ar_log.size() - n0), 32'd2);
    check("rd_ar_first", ar_log[n0], 32'h8);

    // Redirect in the same cycle as the read beat.
    r_delay = 2;
    n0 = ar_log.size();
    pulse_pc_write(32'h10);
    for (int i = 0; i < 20 && !(M_RREADY && M_RVALID); i++) @(negedge CLK);
    pulse_redirect(32'h200);
    check("rv_arvalid", {31'b0, M_ARVALID}, 32'd1);
    check("rv_araddr", M_ARADDR, 32'h200);
    check("rv_insn_nop", INSTRUCTION, NOP);
    wait_done("rv", 40, cyc);
    fetch_check("rv200", 32'h200);
    check("rv_ar_count", 32'(ar_log.size() - n0), 32'd2);

    // Redirect beats a simultaneous PC_WRITE in HOLD.
    r_delay = 0;
    n0 = ar_log.size();
    PC_WRITE = 1'b1; PC_NEXT = 32'h20; REDIRECT = 1'b1; REDIRECT_PC = 32'h300;
    @(negedge CLK);
    PC_WRITE = 1'b0; REDIRECT = 1'b0;
    check("prio_araddr", M_ARADDR, 32'h300);
    wait_done("prio", 40, cyc);
    fetch_check("prio300", 32'h300);
    check("prio_ar_count", 32'(ar_log.size() - n0), 32'd1);

    // Randomized sequential fetches and in-flight redirects.
    for (int it = 0; it < 12; it++) begin
      ar_delay = $urandom_range(0, 3);
      r_delay  = $urandom_range(0, 3);
      t1 = 32'($urandom_range(1, 16383)) << 2;
      t2 = 32'($urandom_range(1, 16383)) << 2;
      n0 = ar_log.size();
      pulse_pc_write(t1);
      if ($urandom_range(0, 1) == 0) begin
        wait_done("rnd_seq", 40, cyc);
        fetch_check("rnd_seq", t1);
      end else begin
        k = $urandom_range(0, 4);
        repeat (k) @(negedge CLK);
        pulse_redirect(t2);
        check("rnd_rd_pc", PC, t2);
        check("rnd_rd_nop", INSTRUCTION, NOP);
        wait_done("rnd_rd", 60, cyc);
        fetch_check("rnd_rd", t2);
        check("rnd_rd_ar_count", 32'(ar_log.size() - n0), 32'd2);
        check("rnd_rd_ar_first", ar_log[n0], t1);
      end
    end
    ar_delay = 0;

    // Timeout boundary: completion on the last allowed cycle wins.
    r_delay = 253;
    pulse_pc_write(32'h44);
    wait_done("tmo_edge", 300, cyc);
    check("tmo_edge_cycles", 32'(cyc), 32'd255);
    check("tmo_edge_nofault", {31'b0, FAULT}, 32'd0);
    fetch_check("tmo_edge", 32'h44);
    r_delay = 254;
    pulse_pc_write(32'h48);
    wait_fault("tmo_data", 300, cyc);
    check("tmo_data_cycles", 32'(cyc), 32'd255);
    check("tmo_data_pc", PC, 32'h48);
    r_delay = 0;
    reset_dut(2);
    wait_done("rst1", 10, cyc);
    fetch_check("rst1", 32'h0);

    // Error response is sticky and stops the bus.
    resp_code = 2'b10;
    pulse_pc_write(32'h40);
    wait_fault("rresp", 20, cyc);
    check("rresp_pc", PC, 32'h40);
    n0 = ar_log.size();
    pulse_pc_write(32'h60);
    bad = 0;
    repeat (5) begin
      @(negedge CLK);
      if (M_ARVALID || M_RREADY || IMEM_BUSY || IMEM_DONE || !FAULT) bad++;
    end
    check("rresp_quiet", 32'(bad), 32'd0);
    check("rresp_no_ar", 32'(ar_log.size() - n0), 32'd0);
    resp_code = 2'b00;
    reset_dut(2);
    wait_done("rst2", 10, cyc);
    fetch_check("rst2", 32'h0);

    // Misaligned PC_NEXT and misaligned redirect.
    n0 = ar_log.size();
    pulse_pc_write(32'h6);
    check("mis_next_fault", {31'b0, FAULT}, 32'd1);
    check("mis_next_pc", PC, 32'h6);
    check("mis_next_arvalid", {31'b0, M_ARVALID}, 32'd0);
    repeat (3) @(negedge CLK);
    check("mis_next_no_ar", 32'(ar_log.size() - n0), 32'd0);
    reset_dut(1);
    wait_done("rst3", 10, cyc);
    pulse_redirect(32'h102);
    check("mis_rd_fault", {31'b0, FAULT}, 32'd1);
    check("mis_rd_pc", PC, 32'h102);
    reset_dut(1);
    wait_done("rst4", 10, cyc);

    // Address phase never accepted.
    ar_stall = 1'b1;
    pulse_pc_write(32'h80);
    arv = 0;
    for (int i = 0; i < 400 && !FAULT; i++) begin
      if (M_ARVALID) arv++;
      @(negedge CLK);
    end
    check("tmo_ar_cycles", 32'(arv), 32'd255);
    check("tmo_ar_fault", {31'b0, FAULT}, 32'd1);
    check("tmo_ar_pc", PC, 32'h80);
    ar_stall = 1'b0;
    reset_dut(2);
    wait_done("rst5", 10, cyc);
    fetch_check("rst5", 32'h0);

    // Reset in the middle of a data phase; the pending beat is dropped.
    r_delay = 3;
    pulse_pc_write(32'h50);
    @(negedge CLK);
    reset_dut(1);
    r_delay = 0;
    wait_done("rst_mid", 10, cyc);
    fetch_check("rst_mid", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
